sw_led_decoder: RTL

- Return path for the switch encoder: takes a 4-bit switch index and drives the 16-LED bank with the matching one-hot pattern.
- A new index is announced visually: the selected LED blinks for a fixed number of phases, then stays lit.
- Updates only when the index changes; the encoder uses the same rule.
- Sits between the switch encoder / CPU address path and the board LED pins.

---
 rtl/sw_led_if.sv | 15 +
 rtl/sw_led_decoder.sv | 77 +++++++
 2 files changed

// File: rtl/sw_led_if.sv
// sw_led_if: index request in, LED bank and status out, between the encoder/CPU side and the decoder
interface sw_led_if #(
    parameter int ADDR_W = 4,
    parameter int N_LED  = 16
);
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic [N_LED-1:0]  led;
    logic [ADDR_W-1:0] cur_addr;
    logic              blinking;
    logic              chg_pulse;

    modport master (output addr, addr_valid, input led, cur_addr, blinking, chg_pulse);
    modport slave  (input addr, addr_valid, output led, cur_addr, blinking, chg_pulse);
endinterface

// File: rtl/sw_led_decoder.sv
// sw_led_decoder: one-hot LED drive for a switch index, blinking to announce each new index
module sw_led_decoder #(
    parameter int N_LED        = 16,
    parameter int ADDR_W       = 4,
    parameter int BLINK_PERIOD = 25_000_000,
    parameter int BLINK_PHASES = 6
) (
    input logic    clk,
    input logic    rst,
    sw_led_if.slave bus
);
    localparam int CW = BLINK_PERIOD > 1 ? $clog2(BLINK_PERIOD) : 1;
    localparam int PW = $clog2(BLINK_PHASES + 1);

    typedef enum logic [1:0] {IDLE, BLINK, STEADY} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [PW-1:0]     phase, phase_n;
    logic              lit, lit_n;
    logic [ADDR_W-1:0] cur, cur_n;
    logic [N_LED-1:0]  led_n;
    logic              accept;

    assign accept       = bus.addr_valid && (state == IDLE || bus.addr != cur);
    assign bus.cur_addr = cur;
    assign bus.blinking = state == BLINK;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        phase_n = phase;
        lit_n   = lit;
        cur_n   = cur;
        if (accept) begin
            state_n = BLINK;
            cnt_n   = '0;
            phase_n = '0;
            lit_n   = 1'b1;
            cur_n   = bus.addr;
        end else if (state == BLINK) begin
            if (cnt == CW'(BLINK_PERIOD - 1)) begin
                cnt_n   = '0;
                lit_n   = !lit;
                phase_n = phase + 1'b1;
                // even phase count means lit is already back on when the blink ends
                if (phase_n == PW'(BLINK_PHASES)) begin
                    state_n = STEADY;
                    phase_n = '0;
                end
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
        led_n = (state_n == STEADY || (state_n == BLINK && lit_n)) ? N_LED'(1) << cur_n : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            phase         <= '0;
            lit           <= 1'b0;
            cur           <= '0;
            bus.led       <= '0;
            bus.chg_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            phase         <= phase_n;
            lit           <= lit_n;
            cur           <= cur_n;
            bus.led       <= led_n;
            bus.chg_pulse <= accept;
        end
    end
endmodule
